l2_arbiter: RTL and testbench

Two-port arbiter that shares the single unified L2 cache between the L1 instruction cache and the L1 data cache. It sits between both L1 miss ports and the L2 request port. It grants one L1 at a time and forwards that L1's line read or write as a held, registered request. It routes the L2 response back to the granted L1 only, and inserts a release cycle so the L2's registered inputs never see a stale request.

---
 rtl/l2_arbiter.sv | 108 ++++++++++
 tb/tb_l2_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Shares one L2 port between the L1 I-cache and D-cache, with a release cycle after each transaction.
// Define L2_ARB_RR_EN for round-robin tie breaking; the default build gives the D-cache fixed priority.
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } state_t;

  state_t state;
  logic   i_req;
  logic   d_req;
  logic   d_win;

  assign i_req = icache_read;
  assign d_req = dcache_read | dcache_write;

`ifdef L2_ARB_RR_EN
  logic last_d;

  // Reset leaves last_d clear so the first tie goes to D.
  assign d_win = d_req & (~i_req | ~last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE) begin
      if (d_win) begin
        last_d <= 1'b1;
      end else if (i_req) begin
        last_d <= 1'b0;
      end
    end
  end
`else
  assign d_win = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_win) begin
            state      <= GRANT_D;
            l2_address <= dcache_address;
            l2_wdata   <= dcache_wdata;
            l2_write   <= dcache_write;
            l2_read    <= dcache_read & ~dcache_write;
          end else if (i_req) begin
            state      <= GRANT_I;
            l2_address <= icache_address;
            l2_read    <= 1'b1;
            l2_write   <= 1'b0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (l2_resp) begin
            state    <= RELEASE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;
  assign icache_resp  = l2_resp & (state == GRANT_I);
  assign dcache_resp  = l2_resp & (state == GRANT_D);

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter with a transaction-level reference model.
// Define L2_ARB_RR_EN here as well to check the round-robin build.
module tb_l2_arbiter;

  logic         clk;
  logic         rst;
  logic         icache_read;
  logic [31:0]  icache_address;
  logic [255:0] icache_rdata;
  logic         icache_resp;
  logic         dcache_read;
  logic         dcache_write;
  logic [31:0]  dcache_address;
  logic [255:0] dcache_wdata;
  logic [255:0] dcache_rdata;
  logic         dcache_resp;
  logic         l2_read;
  logic         l2_write;
  logic [31:0]  l2_address;
  logic [255:0] l2_wdata;
  logic [255:0] l2_rdata;
  logic         l2_resp;

  int total = 0;
  int bad   = 0;

  l2_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk),
    .rst(rst),
    .icache_read(icache_read),
    .icache_address(icache_address),
    .icache_rdata(icache_rdata),
    .icache_resp(icache_resp),
    .dcache_read(dcache_read),
    .dcache_write(dcache_write),
    .dcache_address(dcache_address),
    .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata),
    .dcache_resp(dcache_resp),
    .l2_read(l2_read),
    .l2_write(l2_write),
    .l2_address(l2_address),
    .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata),
    .l2_resp(l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the L2, whether a release cycle is pending,
  // and what the held L2 request must look like.
  int           m_owner;
  logic         m_rel;
  logic         m_pref_d;
  logic         e_read;
  logic         e_write;
  logic [31:0]  e_addr;
  logic [255:0] e_wdata;
  logic         m_ireq;
  logic         m_dreq;
  logic         m_pick_d;

  assign m_ireq   = icache_read;
  assign m_dreq   = dcache_read | dcache_write;
  assign m_pick_d = m_dreq && (!m_ireq || m_pref_d);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner  <= 0;
      m_rel    <= 1'b0;
      m_pref_d <= 1'b1;
      e_read   <= 1'b0;
      e_write  <= 1'b0;
      e_addr   <= '0;
      e_wdata  <= '0;
    end else if (m_rel) begin
      m_rel <= 1'b0;
    end else if (m_owner != 0) begin
      if (l2_resp) begin
        m_owner <= 0;
        m_rel   <= 1'b1;
        e_read  <= 1'b0;
        e_write <= 1'b0;
      end
    end else if (m_pick_d) begin
      m_owner <= 2;
      e_write <= dcache_write;
      e_read  <= dcache_read && !dcache_write;
      e_addr  <= dcache_address;
      e_wdata <= dcache_wdata;
`ifdef L2_ARB_RR_EN
      m_pref_d <= 1'b0;
`endif
    end else if (m_ireq) begin
      m_owner <= 1;
      e_read  <= 1'b1;
      e_write <= 1'b0;
      e_addr  <= icache_address;
`ifdef L2_ARB_RR_EN
      m_pref_d <= 1'b1;
`endif
    end
  end

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison plus bookkeeping for the directed checks.
  int          cyc = 0;
  int          n_iresp = 0;
  int          n_dresp = 0;
  int          n_hi = 0;
  int          d_resp_cyc = 0;
  logic        prev_req = 1'b0;
  logic [31:0] log_addr[$];
  int          log_cyc[$];

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      chk("l2_read", {255'd0, l2_read}, {255'd0, e_read});
      chk("l2_write", {255'd0, l2_write}, {255'd0, e_write});
      chk("l2_address", {224'd0, l2_address}, {224'd0, e_addr});
      chk("l2_wdata", l2_wdata, e_wdata);
      chk("icache_resp", {255'd0, icache_resp},
          {255'd0, l2_resp && m_owner == 1});
      chk("dcache_resp", {255'd0, dcache_resp},
          {255'd0, l2_resp && m_owner == 2});
      chk("icache_rdata", icache_rdata, l2_rdata);
      chk("dcache_rdata", dcache_rdata, l2_rdata);
      if (icache_resp) n_iresp++;
      if (dcache_resp) begin
        n_dresp++;
        d_resp_cyc = cyc;
      end
      if (l2_read) n_hi++;
      if ((l2_read || l2_write) && !prev_req) begin
        log_addr.push_back(l2_address);
        log_cyc.push_back(cyc);
      end
      prev_req = l2_read || l2_write;
    end
  end

  logic         cap_read;
  logic         cap_write;
  logic [31:0]  cap_addr;
  logic [255:0] cap_wdata;

  // Acts as the L2: waits for a request, answers after lat cycles.
  task automatic serve(input int lat, input logic [255:0] data);
    int n;
    n = 0;
    while (!(l2_read || l2_write) && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++;
      $display("FAIL serve_timeout: got no request want request");
    end
    repeat (lat - 1) @(negedge clk);
    cap_read  = l2_read;
    cap_write = l2_write;
    cap_addr  = l2_address;
    cap_wdata = l2_wdata;
    l2_rdata  = data;
    l2_resp   = 1'b1;
    @(negedge clk);
    l2_resp   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  int           s_i;
  int           s_d;
  int           s_hi;
  int           base;
  int           saved;
  logic [255:0] pat;
  logic [31:0]  exp_log[4];

  initial begin
    rst            = 1'b0;
    icache_read    = 1'b0;
    icache_address = '0;
    dcache_read    = 1'b0;
    dcache_write   = 1'b0;
    dcache_address = '0;
    dcache_wdata   = '0;
    l2_rdata       = '0;
    l2_resp        = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_l2_read", {255'd0, l2_read}, 256'd0);
    chk("rst_l2_addr", {224'd0, l2_address}, 256'd0);
    chk("rst_l2_wdata", l2_wdata, 256'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single I-cache read
    s_i = n_iresp; s_d = n_dresp; s_hi = n_hi;
    icache_read    = 1'b1;
    icache_address = 32'h0000_0060;
    pat = {32{8'hA5}};
    serve(5, pat);
    icache_read = 1'b0;
    #3;
    chk("i_addr", {224'd0, cap_addr}, 256'h60);
    chk("i_read_cycles", 256'(n_hi - s_hi), 256'd5);
    chk("i_resp_count", 256'(n_iresp - s_i), 256'd1);
    chk("i_no_dresp", 256'(n_dresp - s_d), 256'd0);
    @(negedge clk);

    // D-cache write
    s_d = n_dresp;
    dcache_write   = 1'b1;
    dcache_address = 32'h0000_1000;
    dcache_wdata   = {8{32'h1234_5678}};
    serve(3, '0);
    dcache_write = 1'b0;
    #3;
    chk("d_release_write", {255'd0, l2_write}, 256'd0);
    chk("d_cap_write", {255'd0, cap_write}, 256'd1);
    chk("d_cap_wdata", cap_wdata, {8{32'h1234_5678}});
    chk("d_resp_count", 256'(n_dresp - s_d), 256'd1);
    @(negedge clk);

    // Tie after reset: D first, I three checks after D's resp
    do_reset();
    icache_read    = 1'b1;
    icache_address = 32'h0000_0100;
    dcache_read    = 1'b1;
    dcache_address = 32'h0000_0200;
    base = log_addr.size();
    serve(3, {8{32'hDEAD_BEEF}});
    dcache_read = 1'b0;
    saved = d_resp_cyc;
    serve(2, {8{32'hCAFE_F00D}});
    icache_read = 1'b0;
    chk("tie_first", {224'd0, log_addr[base]}, 256'h200);
    chk("tie_second", {224'd0, log_addr[base+1]}, 256'h100);
    chk("tie_gap", 256'(log_cyc[base+1] - saved), 256'd3);
    @(negedge clk);

    // Continuous tie for four transactions
    do_reset();
    icache_read = 1'b1;
    dcache_read = 1'b1;
    base = log_addr.size();
    for (int k = 0; k < 4; k++) serve(2, 256'(k));
    icache_read = 1'b0;
    dcache_read = 1'b0;
`ifdef L2_ARB_RR_EN
    exp_log = '{32'h200, 32'h100, 32'h200, 32'h100};
`else
    exp_log = '{32'h200, 32'h200, 32'h200, 32'h200};
`endif
    for (int k = 0; k < 4; k++)
      chk("rr_order", {224'd0, log_addr[base+k]}, {224'd0, exp_log[k]});
    repeat (2) @(negedge clk);

    // Stray l2_resp while idle
    s_i = n_iresp; s_d = n_dresp;
    l2_resp = 1'b1;
    @(negedge clk);
    l2_resp = 1'b0;
    @(negedge clk);
    chk("stray_resp", 256'(n_iresp - s_i + n_dresp - s_d), 256'd0);

    // D drops its read mid-grant
    s_d = n_dresp;
    dcache_read    = 1'b1;
    dcache_address = 32'h0000_0300;
    @(negedge clk);
    @(negedge clk);
    dcache_read = 1'b0;
    serve(4, {8{32'h0F0F_0F0F}});
    chk("drop_held", {255'd0, cap_read}, 256'd1);
    chk("drop_resp", 256'(n_dresp - s_d), 256'd1);
    @(negedge clk);

    // Reset in the middle of a grant
    icache_read    = 1'b1;
    icache_address = 32'h0000_0400;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    icache_read = 1'b0;
    #2;
    chk("midrst_read", {255'd0, l2_read}, 256'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle", {255'd0, l2_read}, 256'd0);
    s_i = n_iresp;
    icache_read    = 1'b1;
    icache_address = 32'h0000_0060;
    serve(1, {32{8'h3C}});
    icache_read = 1'b0;
    chk("after_rst_addr", {224'd0, cap_addr}, 256'h60);
    chk("after_rst_resp", 256'(n_iresp - s_i), 256'd1);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
